// File: rtl/orange_region_tracker.sv
// orange_region_tracker: bins is_orange pixels into left/centre/right columns and publishes a per-frame detect/direction.
// Ports: clk, rst (sync, active-high), active_area, vsync (active-low, 1->0 = frame end), is_orange;
//        direction (one-hot L/C/R), orange_detected, orange_count (last frame total), frame_valid (1-cycle update pulse).
// Define ORANGE_PERSIST_EN to require PERSIST_FRAMES consecutive raw-detect frames before orange_detected rises.
module orange_region_tracker #(
  parameter int H_ACTIVE       = 320,
  parameter int LEFT_EDGE      = 107,
  parameter int RIGHT_EDGE     = 213,
  parameter int DETECT_THRESH  = 500,
  parameter int PERSIST_FRAMES = 3,
  parameter int CNT_W          = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active_area,
  input  logic               vsync,
  input  logic               is_orange,
  output logic [2:0]         direction,
  output logic               orange_detected,
  output logic [CNT_W+1:0]   orange_count,
  output logic               frame_valid
);
  localparam int COL_W = $clog2(H_ACTIVE);
  localparam int TOT_W = CNT_W + 2;
  logic             vsync_d_q, first_q, first_d, v1_q, v1_d, fv_q, fv_d, det_q, det_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] bin_l_q, bin_l_d, bin_c_q, bin_c_d, bin_r_q, bin_r_d;
  logic [CNT_W-1:0] snap_l_q, snap_l_d, snap_c_q, snap_c_d, snap_r_q, snap_r_d;
  logic [TOT_W-1:0] cnt_q, cnt_d, total;
  logic [2:0]       dir_q, dir_d, amax;
  logic             fe, pix, in_l, in_c, in_r, raw, det_new;
`ifdef ORANGE_PERSIST_EN
  logic [3:0]       hit_q, hit_d;
`endif
  always_comb begin
    fe      = vsync_d_q & ~vsync;
    pix     = active_area & is_orange;
    col_d   = active_area ? ((col_q == COL_W'(H_ACTIVE - 1)) ? col_q : col_q + 1'b1) : '0;
    in_l    = pix && (col_q < COL_W'(LEFT_EDGE));
    in_c    = pix && (col_q >= COL_W'(LEFT_EDGE)) && (col_q < COL_W'(RIGHT_EDGE));
    in_r    = pix && (col_q >= COL_W'(RIGHT_EDGE));
    // at frame end the bins restart, so a pixel in that same cycle seeds the new frame
    bin_l_d = fe ? CNT_W'(in_l) : bin_l_q + CNT_W'(in_l && !(&bin_l_q));
    bin_c_d = fe ? CNT_W'(in_c) : bin_c_q + CNT_W'(in_c && !(&bin_c_q));
    bin_r_d = fe ? CNT_W'(in_r) : bin_r_q + CNT_W'(in_r && !(&bin_r_q));
    snap_l_d = fe ? bin_l_q : snap_l_q;
    snap_c_d = fe ? bin_c_q : snap_c_q;
    snap_r_d = fe ? bin_r_q : snap_r_q;
    first_d = first_q & ~fe;
    v1_d    = fe & ~first_q;
    total   = TOT_W'(snap_l_q) + TOT_W'(snap_c_q) + TOT_W'(snap_r_q);
    raw     = total >= TOT_W'(DETECT_THRESH);
    amax    = (snap_c_q >= snap_l_q && snap_c_q >= snap_r_q) ? 3'b010 : (snap_l_q >= snap_r_q) ? 3'b100 : 3'b001;
`ifdef ORANGE_PERSIST_EN
    hit_d   = v1_q ? (raw ? ((hit_q == 4'(PERSIST_FRAMES)) ? hit_q : hit_q + 4'd1) : 4'd0) : hit_q;
    det_new = hit_d == 4'(PERSIST_FRAMES);
`else
    det_new = raw;
`endif
    det_d   = v1_q ? det_new : det_q;
    dir_d   = v1_q ? (det_new ? amax : 3'b000) : dir_q;
    cnt_d   = v1_q ? total : cnt_q;
    fv_d    = v1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d_q <= 1'b0;
      first_q   <= 1'b1;
      v1_q      <= 1'b0;
      fv_q      <= 1'b0;
      det_q     <= 1'b0;
      dir_q     <= '0;
      cnt_q     <= '0;
      col_q     <= '0;
      bin_l_q   <= '0;
      bin_c_q   <= '0;
      bin_r_q   <= '0;
      snap_l_q  <= '0;
      snap_c_q  <= '0;
      snap_r_q  <= '0;
`ifdef ORANGE_PERSIST_EN
      hit_q     <= '0;
`endif
    end else begin
      vsync_d_q <= vsync;
      first_q   <= first_d;
      v1_q      <= v1_d;
      fv_q      <= fv_d;
      det_q     <= det_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      bin_l_q   <= bin_l_d;
      bin_c_q   <= bin_c_d;
      bin_r_q   <= bin_r_d;
      snap_l_q  <= snap_l_d;
      snap_c_q  <= snap_c_d;
      snap_r_q  <= snap_r_d;
`ifdef ORANGE_PERSIST_EN
      hit_q     <= hit_d;
`endif
    end
  end
  assign direction       = dir_q;
  assign orange_detected = det_q;
  assign orange_count    = cnt_q;
  assign frame_valid     = fv_q;
endmodule
